// File: rtl/smiley_pkg.sv
// Shared definitions for the LED smiley pattern generator and checker.
// Holds the face frame constants, the 16-slot expected-pattern lookup,
// the slot count and the checker state enum.
package smiley_pkg;

    localparam int unsigned PAT_W     = 10;
    localparam int unsigned NUM_SLOTS = 16;

    localparam logic [PAT_W-1:0] FRAME0 = 10'b0111111000;
    localparam logic [PAT_W-1:0] FRAME1 = 10'b1000000100;
    localparam logic [PAT_W-1:0] FRAME2 = 10'b1010010100;
    localparam logic [PAT_W-1:0] FRAME3 = 10'b1000000100;
    localparam logic [PAT_W-1:0] FRAME4 = 10'b1011110100;
    localparam logic [PAT_W-1:0] FRAME5 = 10'b1001100100;
    localparam logic [PAT_W-1:0] FRAME6 = 10'b1000000100;
    localparam logic [PAT_W-1:0] FRAME7 = 10'b0111111000;

    typedef enum logic {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } chk_state_e;

    // Slots 0..7 carry the face frames, slots 8..15 are blank.
    function automatic logic [PAT_W-1:0] expected_pat(input logic [3:0] slot);
        logic [PAT_W-1:0] p;
        case (slot)
            4'd0:    p = FRAME0;
            4'd1:    p = FRAME1;
            4'd2:    p = FRAME2;
            4'd3:    p = FRAME3;
            4'd4:    p = FRAME4;
            4'd5:    p = FRAME5;
            4'd6:    p = FRAME6;
            4'd7:    p = FRAME7;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/smiley_slot_timer.sv
// Slot index and intra-slot timer for the smiley pattern checker.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - restart at slot 0, timer 1 (lock edge)
//   step        - consume one sample: advance slot when the dwell is used up,
//                 otherwise bump the timer; neither load nor step holds both
//   slot        - current slot index 0..15
//   at_dwell    - timer has reached DWELL, the next sample belongs to slot+1
module smiley_slot_timer #(
    parameter int unsigned DWELL = 16384,
    localparam int unsigned TW   = $clog2(DWELL + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [3:0] slot,
    output logic       at_dwell
);

    logic [3:0]    slot_q, slot_d;
    logic [TW-1:0] timer_q, timer_d;

    assign at_dwell = (timer_q == TW'(DWELL));

    always_comb begin
        slot_d  = slot_q;
        timer_d = timer_q;
        if (load) begin
            slot_d  = 4'd0;
            timer_d = TW'(1);
        end else if (step) begin
            if (at_dwell) begin
                slot_d  = slot_q + 4'd1;
                timer_d = TW'(1);
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            timer_q <= '0;
        end else begin
            slot_q  <= slot_d;
            timer_q <= timer_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/smiley_pattern_checker.sv
// Receive-side checker for the LED smiley pattern generator. Locks onto the
// 16-slot frame sequence (8 face frames, 8 blank slots) on the blank->frame-0
// edge, tracks the slot, pulses err on any deviation and counts errors.
// Optional build macro SMILEY_PATTERN_CHECKER_STATS_EN enables seq_ok_cnt,
// the count of completed error-free 16-slot periods; otherwise it reads 0.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   pat_in       - W-bit LED pattern under test
//   locked       - tracking the sequence
//   slot         - current slot index 0..15
//   slot_strobe  - one-cycle pulse on slot change, including on lock
//   err          - one-cycle mismatch pulse
//   err_cnt      - saturating mismatch count
//   seq_ok_cnt   - saturating count of clean periods (stats build only)
module smiley_pattern_checker
    import smiley_pkg::*;
#(
    parameter int unsigned W     = 10,
    parameter int unsigned DWELL = 16384,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     pat_in,
    output logic             locked,
    output logic [3:0]       slot,
    output logic             slot_strobe,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      seq_ok_cnt
);

    logic [W-1:0]     p_q, p_qq;
    chk_state_e       state_q, state_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             tmr_load, tmr_step, at_dwell;
    logic [3:0]       slot_cur, exp_idx;
    logic [W-1:0]     exp_pat;
    logic             lock_cond, mismatch;

    smiley_slot_timer #(
        .DWELL (DWELL)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .step     (tmr_step),
        .slot     (slot_cur),
        .at_dwell (at_dwell)
    );

    // A blank sample followed by frame 0 is the only unambiguous slot boundary.
    assign lock_cond = (p_q == W'(FRAME0)) && (p_qq == '0);
    assign exp_idx   = at_dwell ? slot_cur + 4'd1 : slot_cur;
    assign exp_pat   = W'(expected_pat(exp_idx));
    assign mismatch  = (state_q == TRACK) && (p_q != exp_pat);

    always_comb begin
        state_d   = state_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        tmr_load  = 1'b0;
        tmr_step  = 1'b0;
        case (state_q)
            SEARCH: begin
                if (lock_cond) begin
                    state_d  = TRACK;
                    tmr_load = 1'b1;
                    strobe_d = 1'b1;
                end
            end
            TRACK: begin
                if (mismatch) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    // Slot/timer hold unless the same sample re-establishes lock.
                    if (lock_cond) begin
                        tmr_load = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = SEARCH;
                    end
                end else begin
                    tmr_step = 1'b1;
                    strobe_d = at_dwell;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= '0;
            p_qq      <= '0;
            state_q   <= SEARCH;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            p_q       <= pat_in;
            p_qq      <= p_q;
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef SMILEY_PATTERN_CHECKER_STATS_EN
    logic        clean_q, clean_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic        wrap;

    // A clean advance out of slot 15 closes a full period.
    assign wrap = tmr_step && at_dwell && (slot_cur == 4'd15);

    always_comb begin
        clean_d  = clean_q;
        ok_cnt_d = ok_cnt_q;
        if (tmr_load) begin
            clean_d = 1'b1;
        end else if (mismatch) begin
            clean_d = 1'b0;
        end else if (wrap && clean_q && (ok_cnt_q != '1)) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q  <= 1'b0;
            ok_cnt_q <= '0;
        end else begin
            clean_q  <= clean_d;
            ok_cnt_q <= ok_cnt_d;
        end
    end

    assign seq_ok_cnt = ok_cnt_q;
`else
    assign seq_ok_cnt = '0;
`endif

    assign locked      = (state_q == TRACK);
    assign slot        = slot_cur;
    assign slot_strobe = strobe_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_smiley_pattern_checker.sv
module tb_smiley_pattern_checker;

    localparam int W      = 10;
    localparam int DWELL  = 4;
    localparam int ERR_W  = 2;
    localparam int ERRMAX = (1 << ERR_W) - 1;
    localparam int PERIOD = 16 * DWELL;
`ifdef SMILEY_PATTERN_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     pat_in = '0;
    logic             locked, slot_strobe, err;
    logic [3:0]       slot;
    logic [ERR_W-1:0] err_cnt;
    logic [15:0]      seq_ok_cnt;

    smiley_pattern_checker #(
        .W     (W),
        .DWELL (DWELL),
        .ERR_W (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pat_in      (pat_in),
        .locked      (locked),
        .slot        (slot),
        .slot_strobe (slot_strobe),
        .err         (err),
        .err_cnt     (err_cnt),
        .seq_ok_cnt  (seq_ok_cnt)
    );

    always #5 clk = ~clk;

    logic [9:0] tbl [16] = '{10'b0111111000, 10'b1000000100, 10'b1010010100, 10'b1000000100,
                             10'b1011110100, 10'b1001100100, 10'b1000000100, 10'b0111111000,
                             10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the 64-sample period since lock.
    bit         m_locked, m_strobe, m_err, m_clean;
    int         m_pos, m_errcnt, m_okcnt;
    logic [3:0] m_slot;
    logic [9:0] a1, a2;
    logic [5:0] gcnt;
    int         ok_before;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_strobe = 0; m_err = 0; m_clean = 0;
        m_pos = 0; m_errcnt = 0; m_okcnt = 0; m_slot = 0;
        a1 = '0; a2 = '0;
    endtask

    task automatic relock();
        m_locked = 1; m_pos = 0; m_slot = 0; m_strobe = 1; m_clean = 1;
    endtask

    task automatic model_edge(input logic [9:0] v);
        bit         lockc;
        int         npos;
        logic [9:0] ev;
        lockc    = (a1 == tbl[0]) && (a2 == 10'd0);
        m_err    = 0;
        m_strobe = 0;
        if (!m_locked) begin
            if (lockc) relock();
        end else begin
            npos = (m_pos + 1) % PERIOD;
            ev   = tbl[npos / DWELL];
            if (a1 !== ev) begin
                m_err = 1;
                if (m_errcnt < ERRMAX) m_errcnt++;
                m_clean = 0;
                if (lockc) relock();
                else m_locked = 0;
            end else begin
                m_pos = npos;
                if (npos % DWELL == 0) begin
                    m_strobe = 1;
                    m_slot   = 4'(npos / DWELL);
                    if (npos == 0 && m_clean && m_okcnt < 65535) m_okcnt++;
                end
            end
        end
        a2 = a1;
        a1 = v;
    endtask

    task automatic check_outputs();
        chk("locked", locked, m_locked);
        chk("slot", slot, m_slot);
        chk("slot_strobe", slot_strobe, m_strobe);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_errcnt);
        chk("seq_ok_cnt", seq_ok_cnt, STATS ? m_okcnt : 0);
    endtask

    task automatic cycle(input logic [9:0] v);
        pat_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_outputs();
    endtask

    task automatic reset_cycle(input logic [9:0] v);
        pat_in = v;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic gen_run(input int n, input int inj, input logic [9:0] mask, input int hold);
        logic [9:0] v;
        for (int i = 0; i < n; i++) begin
            v = tbl[gcnt[5:2]];
            if (i == inj) v = v ^ mask;
            cycle(v);
            if (i != hold) gcnt = gcnt + 6'd1;
        end
    endtask

    initial begin
        int n, tgt;
        logic [9:0] v;

        // Reset held with random input, then release with a quiet bus.
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 5; i++) reset_cycle(10'($urandom));
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(10'd0);
            chk("release_locked", locked, 0);
        end

        // Clean sequence from a blank slot, two full periods after lock.
        gcnt = 6'(32 + $urandom_range(0, 31));
        n = 64 - int'(gcnt) + 1 + 2 * PERIOD + 2;
        gen_run(n, -1, 10'd0, -1);
        chk("clean_ok_cnt", seq_ok_cnt, STATS ? 2 : 0);
        chk("clean_err_cnt", err_cnt, 0);

        // Single flipped bit 0 inside slot 2, relock at the next slot 0.
        ok_before = m_okcnt;
        tgt = 8 + $urandom_range(0, 3);
        n = (tgt - int'(gcnt)) & 63;
        gen_run(n + 80, n, 10'h001, -1);
        chk("flip_err_cnt", err_cnt, 1);
        chk("flip_relocked", locked, 1);
        chk("flip_ok_cnt", seq_ok_cnt, STATS ? ok_before : 0);

        // Release from reset while the generator is in slot 5.
        #3 rst_n = 0;
        model_reset();
        reset_cycle(10'($urandom));
        rst_n = 1;
        gcnt = 6'(20 + $urandom_range(0, 3));
        gen_run(64 - int'(gcnt) + 1 + 8, -1, 10'd0, -1);
        chk("late_err_cnt", err_cnt, 0);
        chk("late_locked", locked, 1);

        // Slot 4 stretched to five samples.
        n = (19 - int'(gcnt)) & 63;
        gen_run(n + 3, -1, 10'd0, n);
        chk("stretch_err_cnt", err_cnt, 1);
        chk("stretch_locked", locked, 0);

        // Five more injected errors, each after a relock: counter saturates.
        for (int k = 0; k < 5; k++) begin
            gen_run(66, -1, 10'd0, -1);
            chk("inj_locked", locked, 1);
            gen_run(8, $urandom_range(0, 7), 10'($urandom_range(1, 1023)), -1);
        end
        chk("sat_err_cnt", err_cnt, ERRMAX);

        // Random noise with occasional plausible frames.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 10'd0;
                1:       v = tbl[$urandom_range(0, 7)];
                2:       v = tbl[0];
                default: v = 10'($urandom);
            endcase
            cycle(v);
        end

        // Asynchronous reset mid-TRACK clears outputs without a clock edge.
        gen_run(70, -1, 10'd0, -1);
        chk("pre_async_locked", locked, 1);
        #3 rst_n = 0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_slot", slot, 0);
        chk("async_strobe", slot_strobe, 0);
        chk("async_err", err, 0);
        chk("async_err_cnt", err_cnt, 0);
        chk("async_ok_cnt", seq_ok_cnt, 0);
        model_reset();
        reset_cycle(10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
